// File: rtl/bpm_link_arbiter.sv
// bpm_link_arbiter: merges the CCW/CW BPM Aurora RX streams into one AXI-Stream.
// Each link has a packet FIFO with a speculative write pointer. Only complete,
// well-formed, non-duplicate 5-word packets are committed. The output side
// round-robins whole packets between the two links.
// Optional feature macro: BPM_ARB_DEDUP_EN enables the per-FA-cycle seen-bitmap
// duplicate filter. Without it, every valid packet is forwarded and cnt_dup stays 0.
module bpm_link_arbiter #(
  parameter int          FIFO_AW = 4,
  parameter logic [15:0] MAGIC   = 16'hA5BE,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FAstrobe,
  input  logic [31:0]      ccw_tdata,
  input  logic             ccw_tvalid,
  input  logic             ccw_tlast,
  input  logic [31:0]      cw_tdata,
  input  logic             cw_tvalid,
  input  logic             cw_tlast,
  output logic [31:0]      out_tdata,
  output logic             out_tvalid,
  output logic             out_tlast,
  input  logic             out_tready,
  output logic             out_src,
  output logic [CNT_W-1:0] cnt_fwd,
  output logic [CNT_W-1:0] cnt_dup,
  output logic [CNT_W-1:0] cnt_err
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
  typedef logic [PW-1:0] ptr_t;
  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_DISCARD} wr_state_t;
  typedef enum logic {RD_ARB, RD_SEND} rd_state_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Link 0 = CCW, link 1 = CW
  logic [1:0][31:0] in_data;
  logic [1:0]       in_vld, in_last;
  assign in_data = {cw_tdata, ccw_tdata};
  assign in_vld  = {cw_tvalid, ccw_tvalid};
  assign in_last = {cw_tlast, ccw_tlast};

  logic [31:0] mem_q [2][DEPTH];
  wr_state_t   wst_q [2], wst_d [2];
  logic [2:0]  bcnt_q [2], bcnt_d [2];
  ptr_t        spec_q [2], spec_d [2], cmt_q [2], cmt_d [2], rd_q [2], rd_d [2];
  ptr_t        start_q [2], start_d [2], pend_end_q [2], pend_end_d [2];
  ptr_t        pcnt_q [2], pcnt_d [2], base [2], free [2];
  logic [8:0]  idx_q [2], idx_d [2], pidx_q [2], pidx_d [2];
  logic [1:0]  pend_q, pend_d, cmt_ok, dup, err, wr_en, avail, dec;
  logic [FIFO_AW-1:0] wr_addr [2];
  logic [31:0] rdata [2];

  rd_state_t   rstate_q, rstate_d;
  logic        gsel_q, gsel_d, prio_q, prio_d, gsel_n, gnt, load_ok;
  logic [2:0]  rbeat_q, rbeat_d;
  logic        otv_q, otv_d, otl_q, otl_d, osrc_q, osrc_d;
  logic [31:0] otd_q, otd_d;
  logic [CNT_W-1:0] cnt_fwd_q, cnt_err_q;

`ifdef BPM_ARB_DEDUP_EN
  logic [511:0] seen_q, seen_d, seen_eff;
  logic         fa_q, fa_rise;
  logic [CNT_W-1:0] cnt_dup_q;
  assign fa_rise = FAstrobe && !fa_q;
  assign cnt_dup = cnt_dup_q;
`else
  logic unused_ok;
  assign unused_ok = ^{FAstrobe, pidx_q[0], pidx_q[1]};
  assign cnt_dup   = '0;
`endif

  // Commit resolution for packets completed last cycle, then per-link write FSMs
  always_comb begin
`ifdef BPM_ARB_DEDUP_EN
    // A new FA cycle wipes the bitmap before this cycle's commits are recorded
    seen_eff  = fa_rise ? '0 : seen_q;
    cmt_ok[0] = pend_q[0] && !seen_eff[pidx_q[0]];
    cmt_ok[1] = pend_q[1] && !seen_eff[pidx_q[1]] && !(cmt_ok[0] && pidx_q[0] == pidx_q[1]);
    dup       = pend_q & ~cmt_ok;
    seen_d    = seen_eff;
    for (int l = 0; l < 2; l++)
      if (cmt_ok[l]) seen_d[pidx_q[l]] = 1'b1;
`else
    cmt_ok = pend_q;
    dup    = '0;
`endif
    err   = '0;
    wr_en = '0;
    for (int l = 0; l < 2; l++) begin
      wst_d[l]      = wst_q[l];
      bcnt_d[l]     = bcnt_q[l];
      cmt_d[l]      = cmt_ok[l] ? pend_end_q[l] : cmt_q[l];
      start_d[l]    = start_q[l];
      idx_d[l]      = idx_q[l];
      pidx_d[l]     = pidx_q[l];
      pend_end_d[l] = pend_end_q[l];
      pend_d[l]     = 1'b0;
      // A rejected duplicate rolls back to the committed pointer; a header
      // arriving in the same cycle is written at the rolled-back location.
      base[l]       = dup[l] ? cmt_q[l] : spec_q[l];
      free[l]       = ptr_t'(DEPTH) - (base[l] - rd_q[l]);
      spec_d[l]     = base[l];
      wr_addr[l]    = spec_q[l][FIFO_AW-1:0];
      case (wst_q[l])
        W_IDLE: if (in_vld[l]) begin
          idx_d[l] = in_data[l][8:0];
          if (in_data[l][31:16] == MAGIC && free[l] >= ptr_t'(5)) begin
            if (in_last[l]) err[l] = 1'b1;
            else begin
              wr_en[l]   = 1'b1;
              wr_addr[l] = base[l][FIFO_AW-1:0];
              spec_d[l]  = base[l] + 1'b1;
              start_d[l] = base[l];
              bcnt_d[l]  = 3'd1;
              wst_d[l]   = W_ACCEPT;
            end
          end else begin
            err[l] = 1'b1;
            if (!in_last[l]) wst_d[l] = W_DISCARD;
          end
        end
        W_ACCEPT: if (in_vld[l]) begin
          wr_en[l]  = 1'b1;
          spec_d[l] = spec_q[l] + 1'b1;
          bcnt_d[l] = bcnt_q[l] + 3'd1;
          if (bcnt_q[l] == 3'd4) begin
            if (in_last[l]) begin
              pend_d[l]     = 1'b1;
              pidx_d[l]     = idx_q[l];
              pend_end_d[l] = spec_q[l] + 1'b1;
              wst_d[l]      = W_IDLE;
            end else begin
              err[l]    = 1'b1;
              spec_d[l] = start_q[l];
              wst_d[l]  = W_DISCARD;
            end
          end else if (in_last[l]) begin
            err[l]    = 1'b1;
            spec_d[l] = start_q[l];
            wst_d[l]  = W_IDLE;
          end
        end
        W_DISCARD: if (in_vld[l] && in_last[l]) wst_d[l] = W_IDLE;
        default: wst_d[l] = W_IDLE;
      endcase
    end
  end

  // Committed packets visible to the arbiter include this cycle's commits
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      rdata[l]  = mem_q[l][rd_q[l][FIFO_AW-1:0]];
      avail[l]  = (pcnt_q[l] != '0) || cmt_ok[l];
      dec[l]    = gnt && (gsel_n == 1'(l));
      pcnt_d[l] = pcnt_q[l] + ptr_t'(cmt_ok[l]) - ptr_t'(dec[l]);
    end
  end

  // Read side: packet-granular round-robin feeding a registered AXI output stage
  always_comb begin
    rstate_d = rstate_q;
    gsel_d   = gsel_q;
    prio_d   = prio_q;
    rbeat_d  = rbeat_q;
    otv_d    = otv_q;
    otl_d    = otl_q;
    otd_d    = otd_q;
    osrc_d   = osrc_q;
    gnt      = 1'b0;
    gsel_n   = prio_q;
    for (int l = 0; l < 2; l++) rd_d[l] = rd_q[l];
    load_ok  = !otv_q || out_tready;
    if (otv_q && out_tready) begin
      otv_d = 1'b0;
      otl_d = 1'b0;
    end
    case (rstate_q)
      RD_ARB: if (load_ok && (avail[0] || avail[1])) begin
        gsel_n         = (avail[0] && avail[1]) ? prio_q : avail[1];
        gnt            = 1'b1;
        gsel_d         = gsel_n;
        prio_d         = ~gsel_n;
        rbeat_d        = 3'd1;
        rstate_d       = RD_SEND;
        otv_d          = 1'b1;
        otl_d          = 1'b0;
        otd_d          = rdata[gsel_n];
        osrc_d         = gsel_n;
        rd_d[gsel_n]   = rd_q[gsel_n] + 1'b1;
      end
      RD_SEND: if (load_ok) begin
        otv_d          = 1'b1;
        otl_d          = (rbeat_q == 3'd4);
        otd_d          = rdata[gsel_q];
        rd_d[gsel_q]   = rd_q[gsel_q] + 1'b1;
        rbeat_d        = rbeat_q + 3'd1;
        if (rbeat_q == 3'd4) rstate_d = RD_ARB;
      end
      default: rstate_d = RD_ARB;
    endcase
  end

  // FIFO storage; emptiness is tracked by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++)
      if (wr_en[l]) mem_q[l][wr_addr[l]] <= in_data[l];
  end

  // State, pointers, output stage and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        wst_q[l] <= W_IDLE;     bcnt_q[l] <= '0;      spec_q[l] <= '0;
        cmt_q[l] <= '0;         rd_q[l] <= '0;        start_q[l] <= '0;
        pend_end_q[l] <= '0;    pcnt_q[l] <= '0;      idx_q[l] <= '0;
        pidx_q[l] <= '0;
      end
      pend_q    <= '0;
      rstate_q  <= RD_ARB;
      gsel_q    <= 1'b0;
      prio_q    <= 1'b0;
      rbeat_q   <= '0;
      otv_q     <= 1'b0;
      otl_q     <= 1'b0;
      otd_q     <= '0;
      osrc_q    <= 1'b0;
      cnt_fwd_q <= '0;
      cnt_err_q <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        wst_q[l] <= wst_d[l];   bcnt_q[l] <= bcnt_d[l]; spec_q[l] <= spec_d[l];
        cmt_q[l] <= cmt_d[l];   rd_q[l] <= rd_d[l];     start_q[l] <= start_d[l];
        pend_end_q[l] <= pend_end_d[l];  pcnt_q[l] <= pcnt_d[l];
        idx_q[l] <= idx_d[l];   pidx_q[l] <= pidx_d[l];
      end
      pend_q    <= pend_d;
      rstate_q  <= rstate_d;
      gsel_q    <= gsel_d;
      prio_q    <= prio_d;
      rbeat_q   <= rbeat_d;
      otv_q     <= otv_d;
      otl_q     <= otl_d;
      otd_q     <= otd_d;
      osrc_q    <= osrc_d;
      cnt_err_q <= sat_add(cnt_err_q, {1'b0, err[0]} + {1'b0, err[1]});
      if (otv_q && out_tready && otl_q) cnt_fwd_q <= sat_add(cnt_fwd_q, 2'd1);
    end
  end

`ifdef BPM_ARB_DEDUP_EN
  // Seen bitmap, FA edge history and duplicate counter
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q    <= '0;
      fa_q      <= 1'b0;
      cnt_dup_q <= '0;
    end else begin
      seen_q    <= seen_d;
      fa_q      <= FAstrobe;
      cnt_dup_q <= sat_add(cnt_dup_q, {1'b0, dup[0]} + {1'b0, dup[1]});
    end
  end
`endif

  assign out_tdata  = otd_q;
  assign out_tvalid = otv_q;
  assign out_tlast  = otl_q;
  assign out_src    = osrc_q;
  assign cnt_fwd    = cnt_fwd_q;
  assign cnt_err    = cnt_err_q;
endmodule
